// File: rtl/axi_fb_rw_arbiter.sv
// AXI4 slave front-end for the VGA frame buffer. Read and write bursts are served one
// at a time, round-robin per burst, on a single-port block RAM with 1-cycle read latency.
module axi_fb_rw_arbiter #(
    parameter int C_RAM_AWIDTH = 10,
    parameter int C_ID_WIDTH   = 1
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    // write address
    input  logic [C_ID_WIDTH-1:0]   S_AXI_AWID,
    input  logic [31:0]             S_AXI_AWADDR,
    input  logic [7:0]              S_AXI_AWLEN,
    input  logic [1:0]              S_AXI_AWBURST,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    // write data
    input  logic [31:0]             S_AXI_WDATA,
    input  logic [3:0]              S_AXI_WSTRB,
    input  logic                    S_AXI_WLAST,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    // write response
    output logic [C_ID_WIDTH-1:0]   S_AXI_BID,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    // read address
    input  logic [C_ID_WIDTH-1:0]   S_AXI_ARID,
    input  logic [31:0]             S_AXI_ARADDR,
    input  logic [7:0]              S_AXI_ARLEN,
    input  logic [1:0]              S_AXI_ARBURST,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    // read data
    output logic [C_ID_WIDTH-1:0]   S_AXI_RID,
    output logic [31:0]             S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RLAST,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    // block RAM port
    output logic                    ram_en,
    output logic [3:0]              ram_we,
    output logic [C_RAM_AWIDTH-1:0] ram_addr,
    output logic [31:0]             ram_wdata,
    input  logic [31:0]             ram_rdata
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_ADDR = 3'd1;
    localparam logic [2:0] WR_DATA = 3'd2;
    localparam logic [2:0] WR_RESP = 3'd3;
    localparam logic [2:0] RD_ADDR = 3'd4;
    localparam logic [2:0] RD_REQ  = 3'd5;
    localparam logic [2:0] RD_LAT  = 3'd6;
    localparam logic [2:0] RD_DATA = 3'd7;

    localparam logic [1:0]              BURST_FIXED = 2'b00;
    localparam logic [C_RAM_AWIDTH-1:0] ADDR_ONE    = 1;

    typedef struct packed {
        logic [C_ID_WIDTH-1:0]   id;
        logic [C_RAM_AWIDTH-1:0] addr;
        logic [7:0]              len;
        logic [1:0]              burst;
    } burst_ctx_t;

    logic [2:0]              state, state_nxt;
    burst_ctx_t              ctx;
    logic [7:0]              cnt;
    logic                    err;
    logic                    last_wr;
    logic                    awready_q, arready_q, wready_q, bvalid_q, rvalid_q;
    logic [31:0]             rdata_q;

    logic                    w_hs, b_hs, r_hs;
    logic                    beat_last, w_end;
    logic [C_RAM_AWIDTH-1:0] addr_nxt;

    // Byte-lane and out-of-window address bits are not decoded by this RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{S_AXI_AWADDR[31:C_RAM_AWIDTH+2], S_AXI_AWADDR[1:0],
                                S_AXI_ARADDR[31:C_RAM_AWIDTH+2], S_AXI_ARADDR[1:0]};

    assign w_hs      = (state == WR_DATA) && wready_q && S_AXI_WVALID;
    assign b_hs      = bvalid_q && S_AXI_BREADY;
    assign r_hs      = rvalid_q && S_AXI_RREADY;
    assign beat_last = (cnt == ctx.len);
    assign w_end     = beat_last || S_AXI_WLAST;
    // WRAP is treated as INCR; the address simply rolls over at the top of the RAM.
    assign addr_nxt  = (ctx.burst == BURST_FIXED) ? ctx.addr : ctx.addr + ADDR_ONE;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (S_AXI_AWVALID && (!S_AXI_ARVALID || !last_wr))
                    state_nxt = WR_ADDR;
                else if (S_AXI_ARVALID)
                    state_nxt = RD_ADDR;
            end
            WR_ADDR: state_nxt = WR_DATA;
            WR_DATA: if (w_hs && w_end) state_nxt = WR_RESP;
            WR_RESP: if (b_hs) state_nxt = IDLE;
            RD_ADDR: state_nxt = RD_REQ;
            RD_REQ:  state_nxt = RD_LAT;
            RD_LAT:  state_nxt = RD_DATA;
            RD_DATA: if (r_hs) state_nxt = beat_last ? IDLE : RD_REQ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            last_wr   <= 1'b0;
            ctx       <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            rdata_q   <= '0;
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            // Handshake outputs are decoded from the next state so they are pure flops.
            awready_q <= (state_nxt == WR_ADDR);
            arready_q <= (state_nxt == RD_ADDR);
            wready_q  <= (state_nxt == WR_DATA);
            bvalid_q  <= (state_nxt == WR_RESP);
            rvalid_q  <= (state_nxt == RD_DATA);

            case (state)
                WR_ADDR: begin
                    ctx.id    <= S_AXI_AWID;
                    ctx.addr  <= S_AXI_AWADDR[C_RAM_AWIDTH+1:2];
                    ctx.len   <= S_AXI_AWLEN;
                    ctx.burst <= S_AXI_AWBURST;
                    cnt       <= '0;
                    err       <= 1'b0;
                end
                WR_DATA: begin
                    if (w_hs) begin
                        ctx.addr <= addr_nxt;
                        cnt      <= cnt + 8'd1;
                        if (S_AXI_WLAST != beat_last) err <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (b_hs) last_wr <= 1'b1;
                end
                RD_ADDR: begin
                    ctx.id    <= S_AXI_ARID;
                    ctx.addr  <= S_AXI_ARADDR[C_RAM_AWIDTH+1:2];
                    ctx.len   <= S_AXI_ARLEN;
                    ctx.burst <= S_AXI_ARBURST;
                    cnt       <= '0;
                end
                RD_LAT: rdata_q <= ram_rdata;
                RD_DATA: begin
                    if (r_hs) begin
                        if (beat_last) begin
                            last_wr <= 1'b0;
                        end else begin
                            ctx.addr <= addr_nxt;
                            cnt      <= cnt + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BID     = ctx.id;
    assign S_AXI_BRESP   = {err & bvalid_q, 1'b0};
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RID     = ctx.id;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RLAST   = rvalid_q & beat_last;

    // RAM strobes follow the W handshake combinationally; reads issue from RD_REQ only.
    assign ram_en    = w_hs || (state == RD_REQ);
    assign ram_we    = w_hs ? S_AXI_WSTRB : 4'h0;
    assign ram_addr  = ram_en ? ctx.addr : '0;
    assign ram_wdata = w_hs ? S_AXI_WDATA : 32'h0;

endmodule

// File: tb/tb_axi_fb_rw_arbiter.sv
// Directed bench for axi_fb_rw_arbiter: behavioural block RAM, RAM-write log,
// grant-order log and a one-burst-in-flight monitor.
module tb_axi_fb_rw_arbiter;
    localparam int AW = 10;
    localparam int IW = 2;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic [IW-1:0] S_AXI_AWID = '0, S_AXI_ARID = '0, S_AXI_BID, S_AXI_RID;
    logic [31:0]   S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
    logic [7:0]    S_AXI_AWLEN = '0, S_AXI_ARLEN = '0;
    logic [1:0]    S_AXI_AWBURST = '0, S_AXI_ARBURST = '0;
    logic          S_AXI_AWVALID = 1'b0, S_AXI_ARVALID = 1'b0, S_AXI_AWREADY, S_AXI_ARREADY;
    logic [31:0]   S_AXI_WDATA = '0, S_AXI_RDATA;
    logic [3:0]    S_AXI_WSTRB = '0;
    logic          S_AXI_WLAST = 1'b0, S_AXI_WVALID = 1'b0, S_AXI_WREADY;
    logic [1:0]    S_AXI_BRESP, S_AXI_RRESP;
    logic          S_AXI_BVALID, S_AXI_BREADY = 1'b0;
    logic          S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY = 1'b0;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;

    always #5 ACLK = ~ACLK;

    axi_fb_rw_arbiter #(.C_RAM_AWIDTH(AW), .C_ID_WIDTH(IW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // single-port RAM, one-cycle read latency
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge ACLK) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic [127:0] outs();
        outs = {35'd0, S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID,
                S_AXI_RLAST, S_AXI_BRESP, S_AXI_RRESP, S_AXI_BID, S_AXI_RID, S_AXI_RDATA,
                ram_en, ram_we, ram_addr, ram_wdata};
    endfunction

    typedef struct packed {
        logic [AW-1:0] a;
        logic [3:0]    we;
        logic [31:0]   d;
    } wrec_t;

    wrec_t       wl[$];
    logic [7:0]  grants[$];
    int          en_cnt = 0;
    logic        busy = 1'b0;

    // mid-cycle monitor: RAM writes, RAM enables, grants, one burst at a time
    initial forever begin
        @(negedge ACLK);
        if (!ARESETN) begin
            busy = 1'b0;
        end else begin
            if (ram_en) en_cnt++;
            if (ram_en && ram_we != 4'h0) wl.push_back({ram_addr, ram_we, ram_wdata});
            if (S_AXI_AWREADY || S_AXI_ARREADY) begin
                chk("excl", 128'(busy), 128'(0));
                busy = 1'b1;
                grants.push_back(S_AXI_AWREADY ? 8'h57 : 8'h52);
            end
            if (S_AXI_BVALID && S_AXI_BREADY) busy = 1'b0;
            if (S_AXI_RVALID && S_AXI_RREADY && S_AXI_RLAST) busy = 1'b0;
        end
    end

    // compare the RAM-write log with n words at a0 (step 0 or 1), data base+k
    task automatic chk_wl(input string tag, input int n, input logic [AW-1:0] a0,
                          input int step, input logic [31:0] base);
        logic [AW-1:0] a;
        chk({tag, "_n"}, 128'(wl.size()), 128'(n));
        a = a0;
        for (int k = 0; k < n && k < wl.size(); k++) begin
            chk(tag, 128'(wl[k]), 128'({a, 4'hF, base + 32'(k)}));
            a = a + AW'(step);
        end
    endtask

    task automatic axi_write(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [31:0] base, input int last_at,
                             input int gap, input bit early, output logic [1:0] resp);
        int n;
        int nb;
        nb = (last_at < int'(len)) ? last_at + 1 : int'(len) + 1;
        S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len; S_AXI_AWBURST = burst;
        S_AXI_AWVALID = 1'b1;
        if (early) begin
            S_AXI_WDATA = base; S_AXI_WSTRB = 4'hF; S_AXI_WLAST = (last_at == 0); S_AXI_WVALID = 1'b1;
        end
        n = 0;
        tick();
        while (!S_AXI_AWREADY && n < 60) begin tick(); n++; end
        chk("aw_grant", 128'(S_AXI_AWREADY), 128'(1));
        tick();
        S_AXI_AWVALID = 1'b0;
        for (int k = 0; k < nb; k++) begin
            if (k > 0 && gap > 0) begin
                S_AXI_WVALID = 1'b0;
                repeat (gap) tick();
            end
            S_AXI_WDATA = base + 32'(k); S_AXI_WSTRB = 4'hF; S_AXI_WLAST = (k == last_at);
            S_AXI_WVALID = 1'b1;
            n = 0;
            while (!S_AXI_WREADY && n < 60) begin tick(); n++; end
            chk("w_ready", 128'(S_AXI_WREADY), 128'(1));
            tick();
        end
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        S_AXI_BREADY = 1'b1;
        n = 0;
        while (!S_AXI_BVALID && n < 60) begin tick(); n++; end
        chk("b_valid", 128'(S_AXI_BVALID), 128'(1));
        chk("bid", 128'(S_AXI_BID), 128'(id));
        resp = S_AXI_BRESP;
        tick();
        S_AXI_BREADY = 1'b0;
    endtask

    logic [31:0] rd_buf [0:15];
    int          rd_ar_cyc;
    int          rd_rv_cyc;

    task automatic axi_read(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int stall, input logic [31:0] exp0);
        int n;
        int cyc;
        S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len; S_AXI_ARBURST = burst;
        S_AXI_ARVALID = 1'b1;
        cyc = 0; n = 0;
        tick(); cyc++;
        while (!S_AXI_ARREADY && n < 60) begin tick(); cyc++; n++; end
        chk("ar_grant", 128'(S_AXI_ARREADY), 128'(1));
        rd_ar_cyc = cyc;
        tick(); cyc++;
        S_AXI_ARVALID = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            n = 0;
            while (!S_AXI_RVALID && n < 60) begin tick(); cyc++; n++; end
            chk("r_valid", 128'(S_AXI_RVALID), 128'(1));
            if (k == 0) rd_rv_cyc = cyc;
            if (k == 0 && stall > 0) begin
                for (int s = 0; s < stall; s++) begin
                    tick(); cyc++;
                    chk("r_stall_v", 128'(S_AXI_RVALID), 128'(1));
                    chk("r_stall_d", 128'(S_AXI_RDATA), 128'(exp0));
                end
            end
            chk("rlast", 128'(S_AXI_RLAST), 128'(k == int'(len)));
            chk("rid", 128'(S_AXI_RID), 128'(id));
            rd_buf[k] = S_AXI_RDATA;
            S_AXI_RREADY = 1'b1;
            tick(); cyc++;
            S_AXI_RREADY = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] resp;
        logic [1:0] resp2;
        int         e0;

        repeat (3) tick();
        chk("rst_outs", outs(), 128'(0));
        ARESETN = 1'b1;
        tick();

        // single write, cycle-accurate
        wl.delete();
        S_AXI_AWID = 2'd1; S_AXI_AWADDR = 32'h200; S_AXI_AWLEN = 8'd0; S_AXI_AWBURST = 2'd1;
        S_AXI_AWVALID = 1'b1;
        tick();
        chk("c1_awready", 128'({S_AXI_AWREADY, S_AXI_WREADY}), 128'(2'b10));
        tick();
        S_AXI_AWVALID = 1'b0;
        chk("c2_wready", 128'(S_AXI_WREADY), 128'(1));
        S_AXI_WDATA = 32'h11223344; S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b1; S_AXI_WVALID = 1'b1;
        #1;
        chk("c2_ram", 128'({ram_en, ram_we, ram_addr, ram_wdata}), 128'({1'b1, 4'hF, 10'h080, 32'h11223344}));
        tick();
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        chk("c3_b", 128'({S_AXI_BVALID, S_AXI_BRESP, S_AXI_BID, S_AXI_WREADY}), 128'({1'b1, 2'b00, 2'd1, 1'b0}));
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        chk("c4_bdone", 128'(S_AXI_BVALID), 128'(0));
        chk_wl("single", 1, 10'h080, 1, 32'h11223344);

        // INCR burst write and read-back
        wl.delete();
        axi_write(2'd2, 32'h100, 8'd4, 2'd1, 32'h12345678, 4, 0, 1'b0, resp);
        chk("incr_bresp", 128'(resp), 128'(0));
        chk_wl("incr", 5, 10'h040, 1, 32'h12345678);
        axi_read(2'd1, 32'h100, 8'd4, 2'd1, 0, 32'h0);
        chk("rd_ar_cyc", 128'(rd_ar_cyc), 128'(1));
        chk("rd_rv_cyc", 128'(rd_rv_cyc), 128'(4));
        for (int k = 0; k < 5; k++) chk("rd_incr", 128'(rd_buf[k]), 128'(32'h12345678 + 32'(k)));

        // address rolls over at the top of the RAM
        wl.delete();
        axi_write(2'd0, 32'hFFC, 8'd1, 2'd1, 32'hA0A00000, 1, 0, 1'b0, resp);
        chk("wrap_bresp", 128'(resp), 128'(0));
        chk("wrap_n", 128'(wl.size()), 128'(2));
        if (wl.size() == 2) chk("wrap_a", 128'({wl[0].a, wl[1].a}), 128'({10'h3FF, 10'h000}));

        // last grant was a write: read wins the tie, early W beats are held off
        wl.delete(); grants.delete();
        fork
            axi_write(2'd1, 32'h600, 8'd1, 2'd1, 32'hC0DE0000, 1, 0, 1'b1, resp);
            axi_read(2'd2, 32'h100, 8'd0, 2'd1, 0, 32'h0);
        join
        chk("tie0_n", 128'(grants.size()), 128'(2));
        if (grants.size() == 2) chk("tie0_ord", 128'({grants[0], grants[1]}), 128'(16'h5257));
        chk_wl("early_w", 2, 10'h180, 1, 32'hC0DE0000);
        chk("tie0_rd", 128'(rd_buf[0]), 128'(32'h12345678));

        // read backpressure: no extra RAM reads while RREADY is low
        e0 = en_cnt;
        axi_read(2'd3, 32'h104, 8'd1, 2'd1, 5, 32'h12345679);
        chk("bp_en", 128'(en_cnt - e0), 128'(2));
        chk("bp_d", 128'({rd_buf[0], rd_buf[1]}), 128'({32'h12345679, 32'h1234567A}));

        // two back-to-back ties after a read: W R W R
        grants.delete();
        fork
            axi_write(2'd1, 32'h700, 8'd0, 2'd1, 32'h55AA0001, 0, 0, 1'b0, resp);
            axi_read(2'd2, 32'h200, 8'd0, 2'd1, 0, 32'h0);
        join
        chk("tie1_rd", 128'(rd_buf[0]), 128'(32'h11223344));
        fork
            axi_write(2'd2, 32'h704, 8'd0, 2'd1, 32'h55AA0002, 0, 0, 1'b0, resp2);
            axi_read(2'd1, 32'h600, 8'd0, 2'd1, 0, 32'h0);
        join
        chk("tie2_rd", 128'(rd_buf[0]), 128'(32'hC0DE0000));
        chk("tie_n", 128'(grants.size()), 128'(4));
        if (grants.size() == 4)
            chk("tie_ord", 128'({grants[0], grants[1], grants[2], grants[3]}), 128'(32'h57525752));

        // W gaps of 3 cycles
        wl.delete();
        axi_write(2'd3, 32'h500, 8'd2, 2'd1, 32'h0BAD0000, 2, 3, 1'b0, resp);
        chk("gap_bresp", 128'(resp), 128'(0));
        chk_wl("gap", 3, 10'h140, 1, 32'h0BAD0000);

        // early WLAST: two writes, SLVERR
        wl.delete();
        axi_write(2'd0, 32'h800, 8'd3, 2'd1, 32'hE0000000, 1, 0, 1'b0, resp);
        chk("err_bresp", 128'(resp), 128'(2'b10));
        chk_wl("err", 2, 10'h200, 1, 32'hE0000000);

        // FIXED burst hits one word; error flag from the previous burst is gone
        wl.delete();
        axi_write(2'd1, 32'h300, 8'd2, 2'd0, 32'hF1F10000, 2, 0, 1'b0, resp);
        chk("fix_bresp", 128'(resp), 128'(0));
        chk_wl("fixed", 3, 10'h0C0, 0, 32'hF1F10000);

        // reset in RD_DATA (last completed grant was a write)
        S_AXI_ARID = 2'd3; S_AXI_ARADDR = 32'h100; S_AXI_ARLEN = 8'd1; S_AXI_ARBURST = 2'd1;
        S_AXI_ARVALID = 1'b1;
        e0 = 0;
        tick();
        while (!S_AXI_ARREADY && e0 < 60) begin tick(); e0++; end
        tick();
        S_AXI_ARVALID = 1'b0;
        e0 = 0;
        while (!S_AXI_RVALID && e0 < 60) begin tick(); e0++; end
        chk("mid_rvalid", 128'(S_AXI_RVALID), 128'(1));
        ARESETN = 1'b0;
        #1;
        chk("mid_rst_outs", outs(), 128'(0));
        repeat (2) tick();
        ARESETN = 1'b1;
        tick();

        // after reset a tie goes to the write again
        wl.delete(); grants.delete();
        fork
            axi_write(2'd2, 32'h900, 8'd0, 2'd1, 32'h600DCAFE, 0, 0, 1'b0, resp);
            axi_read(2'd1, 32'h300, 8'd0, 2'd0, 0, 32'h0);
        join
        chk("post_bresp", 128'(resp), 128'(0));
        chk("post_n", 128'(grants.size()), 128'(2));
        if (grants.size() == 2) chk("post_ord", 128'({grants[0], grants[1]}), 128'(16'h5752));
        chk_wl("post", 1, 10'h240, 1, 32'h600DCAFE);
        chk("post_rd", 128'(rd_buf[0]), 128'(32'hF1F10002));

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/axi_fb_rw_arbiter.md
# axi_fb_rw_arbiter

Single-port frame-buffer access controller behind the AXI4 slave of the CDC VGA core. Accepts AXI4 write bursts (AW/W/B) and read bursts (AR/R) and shares one single-port, 1-cycle-latency block RAM between them. Arbitration is round-robin per burst, and only one burst is in flight at a time. It replaces direct RAM hookup so that concurrent master read and write traffic serializes deterministically.

## Interface
- C_RAM_AWIDTH, 10: RAM word-address width; byte address bits [C_RAM_AWIDTH+1:2] select the word.
- C_ID_WIDTH, 1: AXI ID width.
- ACLK  in  1  sole clock; all logic on rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWID / S_AXI_ARID  in  C_ID_WIDTH  burst ID.
- S_AXI_AWADDR / S_AXI_ARADDR  in  32  byte start address.
- S_AXI_AWLEN / S_AXI_ARLEN  in  8  beats minus 1.
- S_AXI_AWBURST / S_AXI_ARBURST  in  2  0 = FIXED, 1 = INCR, 2 = WRAP (WRAP is handled as INCR).
- S_AXI_AWVALID / S_AXI_ARVALID  in  1;  S_AXI_AWREADY / S_AXI_ARREADY  out  1.
- S_AXI_WDATA  in  32;  S_AXI_WSTRB  in  4;  S_AXI_WLAST  in  1;  S_AXI_WVALID  in  1;  S_AXI_WREADY  out  1.
- S_AXI_BID  out  C_ID_WIDTH;  S_AXI_BRESP  out  2;  S_AXI_BVALID  out  1;  S_AXI_BREADY  in  1.
- S_AXI_RID  out  C_ID_WIDTH;  S_AXI_RDATA  out  32;  S_AXI_RRESP  out  2 (always 00);  S_AXI_RLAST  out  1;  S_AXI_RVALID  out  1;  S_AXI_RREADY  in  1.
- ram_en  out  1;  ram_we  out  4 (byte enables);  ram_addr  out  C_RAM_AWIDTH;  ram_wdata  out  32;  ram_rdata  in  32 (valid one cycle after ram_en with ram_we = 0).

## Operation
- States: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_REQ, RD_LAT, RD_DATA.
- IDLE arbitration:
  - AWVALID only: go to WR_ADDR.
  - ARVALID only: go to RD_ADDR.
  - Both valid: grant the side not granted last (flag last_wr). Reset value of last_wr is 0, so write wins the first tie.
- WR_ADDR:
  - AWREADY = 1 for exactly this cycle. Capture ID, word address, LEN, and BURST; clear the beat counter.
  - Next state is WR_DATA.
- WR_DATA:
  - WREADY = 1.
  - On WVALID & WREADY: ram_en = 1, ram_we = WSTRB, ram_wdata = WDATA, ram_addr = current address. These RAM outputs are combinational from the handshake.
  - After each beat, INCR/WRAP increment the address modulo 2^C_RAM_AWIDTH; FIXED holds it.
  - The burst ends on the beat where count == LEN or WLAST = 1, whichever comes first.
  - An error flag is set if WLAST != (count == LEN) on any beat.
- WR_RESP:
  - BVALID = 1, BID = captured ID, BRESP = 10 (SLVERR) if the error flag is set, else 00.
  - On BREADY: go to IDLE, last_wr = 1.
- RD_ADDR:
  - ARREADY = 1 for exactly this cycle; capture the same fields as a write.
- RD_REQ: ram_en = 1, ram_we = 0, ram_addr = current address.
- RD_LAT: register ram_rdata into S_AXI_RDATA.
- RD_DATA:
  - RVALID = 1, RLAST = (count == LEN), RID = captured ID.
  - RDATA holds stable until the handshake.
  - On RREADY: if last, go to IDLE with last_wr = 0; otherwise advance the address per the burst type, increment count, and go to RD_REQ.
- Outside the handshake cases above, ram_en = 0 and ram_we = 0.
- The channel that is not granted sees READY = 0 until the current burst fully completes, including the B or final R handshake.
- W beats presented before the burst is granted are held off by WREADY = 0.

## Timing
- Reset (asynchronous assert, synchronous release): state = IDLE and last_wr = 0. All READY/VALID outputs, RLAST, BRESP, RRESP, BID, RID, RDATA, ram_en, ram_we, ram_addr, and ram_wdata read 0.
- A reset mid-burst abandons the burst. No B or R response is issued.
- Write burst, cycle 0 = IDLE sampling AWVALID:
  - AWREADY in cycle 1; WREADY from cycle 2.
  - Beat k is written no earlier than cycle 2 + k.
  - BVALID rises the cycle after the last beat.
  - A burst of N beats with no stalls takes N + 3 cycles through the B handshake, then 1 cycle in IDLE.
- Read burst, cycle 0 = IDLE sampling ARVALID:
  - ARREADY in cycle 1, ram_en in cycle 2, first RVALID in cycle 4.
  - Each subsequent beat takes 3 cycles after the RREADY handshake.
- AWREADY, ARREADY, WREADY, BVALID, and RVALID are registered (state-decoded). No READY depends combinationally on a VALID.

## Test plan
- Single write: AW addr 0x200, LEN 0, W 0x11223344, STRB F, WLAST 1 -> ram_addr 0x080, ram_we F once, BRESP 00, BVALID in cycle 3.
- INCR write burst: addr 0x100, LEN 4, data 0x12345678..+4 -> ram_addr 0x40..0x44 written in order, BVALID once, BRESP 00. Read back with AR 0x100, LEN 4 -> same 5 words, RLAST only on beat 5.
- Tie arbitration: AWVALID and ARVALID asserted in the same cycle, twice in succession -> grant order write, read, write, read. The losing READY stays 0 until the winner's B or final R handshake.
- Backpressure: read LEN 1 with RREADY held low for 5 cycles -> RVALID and RDATA stable, no extra ram_en. WVALID gaps of 3 cycles -> no spurious ram_we.
- Protocol error: AWLEN 3 with WLAST on beat 2 -> exactly 2 RAM writes, BRESP 10. A FIXED burst of LEN 2 at 0x300 -> three writes to word 0xC0.
- Reset mid-read: ARESETN low during RD_DATA -> all outputs 0 immediately. After release, a fresh write completes normally with last_wr = 0 behaviour.
